pipelined_subtractor_32bit: RTL and testbench

PIPELINED_SUBTRACTOR_32BIT -- requirements
Module: pipelined_subtractor_32bit

---
 rtl/pipelined_subtractor_32bit_if.sv | 30 +++
 rtl/pipelined_subtractor_32bit.sv | 161 ++++++++++++++++
 tb/tb_pipelined_subtractor_32bit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_32bit_if.sv
// pipelined_subtractor_32bit_if
// Groups the operand and result handshakes of the pipelined 32-bit subtractor.
//   in_valid/in_ready        : operand handshake (upstream -> subtractor)
//   a, b, b_in               : minuend, subtrahend, borrow in
//   out_valid/out_ready      : result handshake (subtractor -> downstream)
//   diff, b_out, ovf         : difference, borrow out, signed overflow
// The master modport is the side that supplies operands and consumes results.
// The slave modport is the subtractor itself.
interface pipelined_subtractor_32bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        b_out;
  logic        ovf;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, ovf
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, ovf
  );
endinterface

// File: rtl/pipelined_subtractor_32bit.sv
// pipelined_subtractor_32bit
// Four-stage, byte-sliced 32-bit subtractor computing (a - b - b_in) mod 2^32,
// with borrow out and signed overflow. Each stage resolves one byte using the
// borrow registered by the stage before it; the untouched upper operand bytes
// travel forward with their transaction.
// Ports:
//   clk   : clock, rising-edge active
//   rst_n : asynchronous active-low reset, empties the pipeline
//   bus   : slave side of pipelined_subtractor_32bit_if (valid/ready in and out)
// A stalled output (out_valid & ~out_ready) freezes every stage and drops
// in_ready; otherwise all stages advance together, bubbles included.
module pipelined_subtractor_32bit (
  input logic                          clk,
  input logic                          rst_n,
  pipelined_subtractor_32bit_if.slave  bus
);

  logic stall;

  // Stage 0: byte 0 resolved, bytes 3..1 of both operands pending
  logic        s0Valid_q,  s0Valid_d;
  logic [7:0]  s0Diff_q,   s0Diff_d;
  logic        s0Borrow_q, s0Borrow_d;
  logic [23:0] s0A_q,      s0A_d;
  logic [23:0] s0B_q,      s0B_d;

  // Stage 1: bytes 1..0 resolved, bytes 3..2 pending
  logic        s1Valid_q,  s1Valid_d;
  logic [15:0] s1Diff_q,   s1Diff_d;
  logic        s1Borrow_q, s1Borrow_d;
  logic [15:0] s1A_q,      s1A_d;
  logic [15:0] s1B_q,      s1B_d;

  // Stage 2: bytes 2..0 resolved, byte 3 pending (carries the sign bits)
  logic        s2Valid_q,  s2Valid_d;
  logic [23:0] s2Diff_q,   s2Diff_d;
  logic        s2Borrow_q, s2Borrow_d;
  logic [7:0]  s2A_q,      s2A_d;
  logic [7:0]  s2B_q,      s2B_d;

  // Stage 3: full result, final borrow and overflow
  logic        s3Valid_q,  s3Valid_d;
  logic [31:0] s3Diff_q,   s3Diff_d;
  logic        s3Borrow_q, s3Borrow_d;
  logic        s3Ovf_q,    s3Ovf_d;

  // One byte slice of the subtraction; the MSB of the 9-bit result is the
  // borrow out because a negative slice difference wraps into bit 8.
  function automatic logic [8:0] subSlice(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic       bin);
    return {1'b0, x} - {1'b0, y} - {8'd0, bin};
  endfunction

  // A result waiting on a downstream that is not ready freezes the pipe.
  assign stall        = s3Valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Next-state for every stage. Holding is the default; when the pipe moves,
  // each stage takes the previous stage's contents plus one more byte.
  // Data of bubbles is loaded too, since the outputs are gated by valid.
  always_comb begin
    s0Valid_d  = s0Valid_q;
    s0Diff_d   = s0Diff_q;
    s0Borrow_d = s0Borrow_q;
    s0A_d      = s0A_q;
    s0B_d      = s0B_q;
    s1Valid_d  = s1Valid_q;
    s1Diff_d   = s1Diff_q;
    s1Borrow_d = s1Borrow_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s2Valid_d  = s2Valid_q;
    s2Diff_d   = s2Diff_q;
    s2Borrow_d = s2Borrow_q;
    s2A_d      = s2A_q;
    s2B_d      = s2B_q;
    s3Valid_d  = s3Valid_q;
    s3Diff_d   = s3Diff_q;
    s3Borrow_d = s3Borrow_q;
    s3Ovf_d    = s3Ovf_q;

    if (!stall) begin
      s0Valid_d                = bus.in_valid;
      {s0Borrow_d, s0Diff_d}   = subSlice(bus.a[7:0], bus.b[7:0], bus.b_in);
      s0A_d                    = bus.a[31:8];
      s0B_d                    = bus.b[31:8];

      s1Valid_d                   = s0Valid_q;
      {s1Borrow_d, s1Diff_d[15:8]} = subSlice(s0A_q[7:0], s0B_q[7:0], s0Borrow_q);
      s1Diff_d[7:0]               = s0Diff_q;
      s1A_d                       = s0A_q[23:8];
      s1B_d                       = s0B_q[23:8];

      s2Valid_d                     = s1Valid_q;
      {s2Borrow_d, s2Diff_d[23:16]} = subSlice(s1A_q[7:0], s1B_q[7:0], s1Borrow_q);
      s2Diff_d[15:0]                = s1Diff_q;
      s2A_d                         = s1A_q[15:8];
      s2B_d                         = s1B_q[15:8];

      s3Valid_d                     = s2Valid_q;
      {s3Borrow_d, s3Diff_d[31:24]} = subSlice(s2A_q, s2B_q, s2Borrow_q);
      s3Diff_d[23:0]                = s2Diff_q;
      // Operands of unlike sign whose result sign differs from a overflowed;
      // this stays exact with a borrow in, including b = 0x7FFFFFFF, b_in = 1.
      s3Ovf_d = (s2A_q[7] ^ s2B_q[7]) & (s3Diff_d[31] ^ s2A_q[7]);
    end
  end

  // Pipeline registers; reset empties every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0Valid_q  <= 1'b0;
      s0Diff_q   <= '0;
      s0Borrow_q <= 1'b0;
      s0A_q      <= '0;
      s0B_q      <= '0;
      s1Valid_q  <= 1'b0;
      s1Diff_q   <= '0;
      s1Borrow_q <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s2Valid_q  <= 1'b0;
      s2Diff_q   <= '0;
      s2Borrow_q <= 1'b0;
      s2A_q      <= '0;
      s2B_q      <= '0;
      s3Valid_q  <= 1'b0;
      s3Diff_q   <= '0;
      s3Borrow_q <= 1'b0;
      s3Ovf_q    <= 1'b0;
    end else begin
      s0Valid_q  <= s0Valid_d;
      s0Diff_q   <= s0Diff_d;
      s0Borrow_q <= s0Borrow_d;
      s0A_q      <= s0A_d;
      s0B_q      <= s0B_d;
      s1Valid_q  <= s1Valid_d;
      s1Diff_q   <= s1Diff_d;
      s1Borrow_q <= s1Borrow_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s2Valid_q  <= s2Valid_d;
      s2Diff_q   <= s2Diff_d;
      s2Borrow_q <= s2Borrow_d;
      s2A_q      <= s2A_d;
      s2B_q      <= s2B_d;
      s3Valid_q  <= s3Valid_d;
      s3Diff_q   <= s3Diff_d;
      s3Borrow_q <= s3Borrow_d;
      s3Ovf_q    <= s3Ovf_d;
    end
  end

  // Results are forced to zero whenever no valid result is presented.
  assign bus.out_valid = s3Valid_q;
  assign bus.diff      = s3Valid_q ? s3Diff_q : 32'd0;
  assign bus.b_out     = s3Valid_q & s3Borrow_q;
  assign bus.ovf       = s3Valid_q & s3Ovf_q;

endmodule

// File: tb/tb_pipelined_subtractor_32bit.sv
// tb_pipelined_subtractor_32bit
// Scoreboard bench for pipelined_subtractor_32bit: each accepted operand set
// pushes its expected result and the edge at which it should be consumed;
// results are popped and compared as the DUT presents them.
module tb_pipelined_subtractor_32bit;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } result_t;

  typedef struct {
    result_t res;
    int      due;
  } entry_t;

  localparam longint MaxSigned = 64'sh7FFFFFFF;
  localparam longint MinSigned = -64'sh80000000;

  logic clk = 1'b0;
  logic rst_n;
  int   edgeNum = 0;
  int   vectors = 0;
  int   miscompares = 0;
  entry_t sb[$];

  pipelined_subtractor_32bit_if bus();

  pipelined_subtractor_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and a count of rising edges used to time results.
  always #5 clk = ~clk;

  always @(posedge clk) edgeNum <= edgeNum + 1;

  // Reference result from plain wide arithmetic, independent of byte slicing.
  function automatic result_t refModel(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic        bin);
    result_t     r;
    logic [32:0] wide;
    longint      sr;
    wide   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    sr     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    r.diff = wide[31:0];
    r.bout = wide[32];
    r.ovf  = (sr > MaxSigned) || (sr < MinSigned);
    return r;
  endfunction

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [33:0] observed,
                             input logic [33:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle ahead of the next rising edge, checks what the DUT shows
  // for that edge, then updates the scoreboard for the handshakes that edge
  // will perform. A stall pushes every pending due edge back by one.
  task automatic applyStimulus(input logic iv, input logic [31:0] a,
                               input logic [31:0] b, input logic bin,
                               input logic ordy, input result_t expRes);
    int      nextEdge;
    logic    expValid;
    logic    expReady;
    result_t cur;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.b_in      = bin;
    bus.out_ready = ordy;
    #1;
    nextEdge = edgeNum + 1;
    expValid = (sb.size() > 0) && (sb[0].due == nextEdge);
    expReady = !(expValid && !ordy);
    cur      = expValid ? sb[0].res : '0;
    checkOutput("out_valid", 34'(bus.out_valid), 34'(expValid));
    checkOutput("result", {bus.diff, bus.b_out, bus.ovf}, cur);
    checkOutput("in_ready", 34'(bus.in_ready), 34'(expReady));
    if (expValid && ordy) begin
      void'(sb.pop_front());
    end else if (expValid) begin
      for (int i = 0; i < sb.size(); i++) sb[i].due++;
    end
    if (iv && expReady && rst_n) sb.push_back('{expRes, nextEdge + 4});
  endtask

  // Bubbles until everything in flight has been consumed, with a bound.
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    checkOutput("drain_empty", 34'(sb.size()), 34'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence: reset, spec vectors, random stream, backpressure,
  // reset with transactions in flight.
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbin;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.b_in      = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", 34'(bus.out_valid), 34'd0);
    checkOutput("reset_result", {bus.diff, bus.b_out, bus.ovf}, 34'd0);
    checkOutput("reset_in_ready", 34'(bus.in_ready), 34'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus(1'b1, 32'h00000005, 32'h00000003, 1'b0, 1'b1, '{32'h00000002, 1'b0, 1'b0});
    applyStimulus(1'b1, 32'h00000000, 32'h00000001, 1'b0, 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0});
    applyStimulus(1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0});
    applyStimulus(1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b0, 1'b1});
    applyStimulus(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, '{32'h80000000, 1'b1, 1'b1});
    applyStimulus(1'b1, 32'h12345678, 32'h7FFFFFFF, 1'b1, 1'b1, '{32'h92345678, 1'b1, 1'b0});
    applyStimulus(1'b1, 32'h80000005, 32'h7FFFFFFF, 1'b1, 1'b1, '{32'h00000005, 1'b0, 1'b1});
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    applyStimulus(1'b1, 32'h0000FF00, 32'h000000FF, 1'b1, 1'b1, '{32'h0000FE00, 1'b0, 1'b0});
    drain();

    $display("[TB] back-to-back random stream");
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = (i % 37 == 0) ? 32'h7FFFFFFF : $urandom;
      rbin = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, ra, rb, rbin, 1'b1, refModel(ra, rb, rbin));
    end
    drain();

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, ra, rb, rbin, 1'b1, refModel(ra, rb, rbin));
    end
    for (int i = 0; i < 5; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      applyStimulus(1'b1, ra, rb, 1'b0, 1'b0, refModel(ra, rb, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      applyStimulus(1'b1, ra, rb, 1'b1, 1'b1, refModel(ra, rb, 1'b1));
    end
    drain();

    $display("[TB] reset with transactions in flight");
    applyStimulus(1'b1, 32'h00000010, 32'h00000001, 1'b0, 1'b1, refModel(32'h10, 32'h1, 1'b0));
    applyStimulus(1'b1, 32'h00000020, 32'h00000002, 1'b0, 1'b1, refModel(32'h20, 32'h2, 1'b0));
    applyStimulus(1'b1, 32'h00000030, 32'h00000003, 1'b0, 1'b1, refModel(32'h30, 32'h3, 1'b0));
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_valid", 34'(bus.out_valid), 34'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 34'(bus.out_valid), 34'd0);
    checkOutput("async_reset_result", {bus.diff, bus.b_out, bus.ovf}, 34'd0);
    checkOutput("async_reset_in_ready", 34'(bus.in_ready), 34'd1);
    sb.delete();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, '0);
    applyStimulus(1'b1, 32'h00000005, 32'h00000003, 1'b0, 1'b1, '{32'h00000002, 1'b0, 1'b0});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
